// File: rtl/keypad_move_if.sv
// -----------------------------------------------------------------------------
// keypad_move_if
//   Bundles the keypad matrix pins and the move-command outputs that
//   keypad_move_encoder exchanges with the board and the connect4 game core.
//
//   Signals
//     kp_row        [3:0]  keypad row sense lines, active-low (pulled up on board)
//     kp_col        [3:0]  keypad column drive, one-cold
//     keypadButton  [3:0]  move column 0..6 for one cycle; 4'hF when idle
//     pop                  1 = pop move, 0 = drop move; valid with a move code
//     pop_armed            pop modifier currently armed (LED)
//
//   Modports
//     master : the encoder (senses rows, drives columns and move outputs)
//     slave  : the board/game side
// -----------------------------------------------------------------------------
interface keypad_move_if;
    logic [3:0] kp_row;
    logic [3:0] kp_col;
    logic [3:0] keypadButton;
    logic       pop;
    logic       pop_armed;

    modport master (
        input  kp_row,
        output kp_col,
        output keypadButton,
        output pop,
        output pop_armed
    );

    modport slave (
        output kp_row,
        input  kp_col,
        input  keypadButton,
        input  pop,
        input  pop_armed
    );
endinterface

// File: rtl/keypad_move_encoder.sv
// -----------------------------------------------------------------------------
// keypad_move_encoder
//   Scans a 4x4 matrix keypad one column at a time, debounces whole-matrix
//   frames and turns a clean single-key press into a one-cycle move command
//   for the connect4 core. Between presses keypadButton holds 4'hF, because
//   the core treats any value below 7 as a move on every cycle.
//
//   Key map (row r, col c -> snapshot bit r*4+c):
//     row 0: 1 2 3 A   row 1: 4 5 6 B   row 2: 7 8 9 C   row 3: 0 F E D
//   Keys 1..7 emit moves 0..6; F toggles the pop modifier, 0 clears it.
//
//   Parameters
//     SCAN_DIV      cycles each column is driven (>= 2)
//     DEBOUNCE_CNT  identical frames needed before the debounced state moves (>= 1)
//
//   Ports
//     clk     system clock
//     reset   synchronous, active-high
//     kp_if   keypad_move_if.master (kp_row in; kp_col, keypadButton, pop,
//             pop_armed out)
//
//   Build option
//     KEYPAD_POP_ARM_EN  when defined, keys F/0 arm/clear the pop modifier and
//                        pop follows it; when undefined only drop moves are
//                        generated and pop/pop_armed stay 0.
// -----------------------------------------------------------------------------
module keypad_move_encoder #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned DEBOUNCE_CNT = 4
) (
    input  logic          clk,
    input  logic          reset,
    keypad_move_if.master kp_if
);
    localparam int unsigned      CNT_W     = $clog2(SCAN_DIV);
    localparam int unsigned      STB_W     = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [STB_W-1:0] STB_MAX   = STB_W'(DEBOUNCE_CNT);
    localparam logic [3:0]       IDLE_CODE = 4'hF;
`ifdef KEYPAD_POP_ARM_EN
    localparam logic [3:0]       BIT_KEY0  = 4'd12;
    localparam logic [3:0]       BIT_KEYF  = 4'd13;
`endif

    typedef enum logic [1:0] {COL0, COL1, COL2, COL3} scan_state_e;
    // DB_MULTI doubles as the post-reset BLOCKED state: a debounced NONE
    // has to be seen before any press can fire.
    typedef enum logic [1:0] {DB_NONE, DB_SINGLE, DB_MULTI} deb_state_e;

    scan_state_e      state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [15:0]      snap_q,   snap_d;    // frame being assembled
    logic [15:0]      prev_q,   prev_d;    // last completed, differing frame
    logic [STB_W-1:0] stable_q, stable_d;
    deb_state_e       deb_q,    deb_d;
    logic [3:0]       button_q, button_d;
    logic             pop_q,    pop_d;
    logic             armed_q,  armed_d;

    logic [15:0] col_snap;   // snap_q with the current column's rows merged in
    logic        last_cnt;
    logic        frame_end;
    deb_state_e  frame_cls;
    logic [3:0]  key_bit;
    logic        is_move;
    logic [3:0]  move_col;

    assign last_cnt  = (cnt_q == CNT_LAST);
    assign frame_end = last_cnt && (state_q == COL3);

    // Frame decode: merge live rows, classify, locate the pressed key.
    always_comb begin
        col_snap = snap_q;
        for (int r = 0; r < 4; r++) begin
            col_snap[{2'(r), state_q}] = ~kp_if.kp_row[r];
        end

        if (col_snap == 16'd0) begin
            frame_cls = DB_NONE;
        end else if ((col_snap & (col_snap - 16'd1)) == 16'd0) begin
            frame_cls = DB_SINGLE;
        end else begin
            frame_cls = DB_MULTI;
        end

        key_bit = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (col_snap[i]) key_bit = 4'(i);
        end

        is_move  = 1'b1;
        move_col = IDLE_CODE;
        case (key_bit)
            4'd0:    move_col = 4'd0;  // key 1
            4'd1:    move_col = 4'd1;  // key 2
            4'd2:    move_col = 4'd2;  // key 3
            4'd4:    move_col = 4'd3;  // key 4
            4'd5:    move_col = 4'd4;  // key 5
            4'd6:    move_col = 4'd5;  // key 6
            4'd8:    move_col = 4'd6;  // key 7
            default: is_move  = 1'b0;
        endcase
    end

    // Next-state logic for scan FSM, debouncer and outputs.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves a value unassigned, which would infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q + CNT_W'(1);
        snap_d   = snap_q;
        prev_d   = prev_q;
        stable_d = stable_q;
        deb_d    = deb_q;
        button_d = IDLE_CODE;
        pop_d    = 1'b0;
        armed_d  = armed_q;

        if (last_cnt) begin
            cnt_d  = '0;
            snap_d = col_snap;
            case (state_q)
                COL0:    state_d = COL1;
                COL1:    state_d = COL2;
                COL2:    state_d = COL3;
                default: state_d = COL0;
            endcase
        end

        if (frame_end) begin
            if (col_snap == prev_q) begin
                if (stable_q != STB_MAX) stable_d = stable_q + STB_W'(1);
            end else begin
                prev_d   = col_snap;
                stable_d = '0;
            end

            if (stable_d == STB_MAX) begin
                deb_d = frame_cls;
                // Only a clean NONE -> SINGLE transition is a press.
                if ((deb_q == DB_NONE) && (frame_cls == DB_SINGLE)) begin
                    if (is_move) button_d = move_col;
`ifdef KEYPAD_POP_ARM_EN
                    if (is_move) begin
                        pop_d   = armed_q;
                        armed_d = 1'b0;
                    end else if (key_bit == BIT_KEYF) begin
                        armed_d = ~armed_q;
                    end else if (key_bit == BIT_KEY0) begin
                        armed_d = 1'b0;
                    end
`else
                    armed_d = 1'b0;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q  <= COL0;
            cnt_q    <= '0;
            snap_q   <= '0;
            prev_q   <= '0;
            stable_q <= '0;
            deb_q    <= DB_MULTI;
            button_q <= IDLE_CODE;
            pop_q    <= 1'b0;
            armed_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            snap_q   <= snap_d;
            prev_q   <= prev_d;
            stable_q <= stable_d;
            deb_q    <= deb_d;
            button_q <= button_d;
            pop_q    <= pop_d;
            armed_q  <= armed_d;
        end
    end

    assign kp_if.kp_col       = ~(4'b0001 << state_q);
    assign kp_if.keypadButton = button_q;
    assign kp_if.pop          = pop_q;
    assign kp_if.pop_armed    = armed_q;

endmodule

// File: tb/tb_keypad_move_encoder.sv
// -----------------------------------------------------------------------------
// tb_keypad_move_encoder
//   Directed bench for keypad_move_encoder with SCAN_DIV=4, DEBOUNCE_CNT=2
//   (16-cycle frames). A keypad model pulls kp_row[r] low when a pressed key
//   (r,c) has its column driven low. A negedge monitor records every cycle
//   where keypadButton leaves 4'hF, so pulse counts and widths are checked.
//   Expectations for pop/pop_armed follow KEYPAD_POP_ARM_EN.
// -----------------------------------------------------------------------------
module tb_keypad_move_encoder;
    localparam int FRAME = 16;
`ifdef KEYPAD_POP_ARM_EN
    localparam logic ARM_EN = 1'b1;
`else
    localparam logic ARM_EN = 1'b0;
`endif

    // Key masks: bit r*4+c
    localparam logic [15:0] M_K1 = 16'h0001;
    localparam logic [15:0] M_K2 = 16'h0002;
    localparam logic [15:0] M_K3 = 16'h0004;
    localparam logic [15:0] M_K4 = 16'h0010;
    localparam logic [15:0] M_K5 = 16'h0020;
    localparam logic [15:0] M_K7 = 16'h0100;
    localparam logic [15:0] M_K0 = 16'h1000;
    localparam logic [15:0] M_KF = 16'h2000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pressed = '0;
    logic [3:0]  kp_row_v;

    int n_checks = 0;
    int n_errors = 0;

    int         pulse_cnt = 0;
    logic [3:0] last_btn = 4'hF;
    logic       last_pop = 1'b0;
    logic       last_armed = 1'b0;

    keypad_move_if kp_bus();

    keypad_move_encoder #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kp_if (kp_bus)
    );

    always #5 clk = ~clk;

    // Keypad matrix model
    always_comb begin
        kp_row_v = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !kp_bus.kp_col[c]) kp_row_v[r] = 1'b0;
            end
        end
    end
    assign kp_bus.kp_row = kp_row_v;

    // Pulse monitor
    always @(negedge clk) begin
        if (!reset && kp_bus.keypadButton != 4'hF) begin
            pulse_cnt  = pulse_cnt + 1;
            last_btn   = kp_bus.keypadButton;
            last_pop   = kp_bus.pop;
            last_armed = kp_bus.pop_armed;
        end
    end

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic wait_frames(input int n);
        repeat (n * FRAME) @(negedge clk);
    endtask

    task automatic hold(input logic [15:0] mask, input int frames);
        pressed = mask;
        wait_frames(frames);
    endtask

    // Stops at the negedge of cycle 0 of the next frame (COL0, count 0).
    task automatic align_frame();
        int n;
        n = 0;
        while (kp_bus.kp_col != 4'b0111 && n < 40) begin @(negedge clk); n++; end
        while (kp_bus.kp_col != 4'b1110 && n < 40) begin @(negedge clk); n++; end
        check("align_timeout", 32'(n < 40), 32'd1);
    endtask

    initial begin
        int         base;
        int         lat;
        logic [3:0] exp_col;

        // ---------------- reset and scan ----------------
        reset   = 1'b1;
        pressed = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_kp_col", kp_bus.kp_col, 4'b1110);
        check("rst_button", kp_bus.keypadButton, 4'hF);
        check("rst_pop", kp_bus.pop, 1'b0);
        check("rst_armed", kp_bus.pop_armed, 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp_col = ~(4'b0001 << ((i / 4) % 4));
            check($sformatf("scan_col_%0d", i), kp_bus.kp_col, exp_col);
            @(negedge clk);
        end
        check("scan_no_pulse", pulse_cnt, 0);

        // ---------------- single drop move (key 3) ----------------
        align_frame();
        base    = pulse_cnt;
        pressed = M_K3;
        lat     = 0;
        while (kp_bus.keypadButton == 4'hF && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        // Pressed at cycle 0: stored at frame end 1, stable 1 at end 2,
        // qualifies at end 3 -> visible in cycle 48.
        check("drop_latency", lat, 48);
        check("drop_button", kp_bus.keypadButton, 4'd2);
        check("drop_pop", kp_bus.pop, 1'b0);
        @(negedge clk);
        check("drop_width", kp_bus.keypadButton, 4'hF);
        wait_frames(7);
        hold('0, 4);
        check("drop_count", pulse_cnt - base, 1);

        // ---------------- pop arming ----------------
        base = pulse_cnt;
        hold(M_KF, 4);
        check("arm_set", kp_bus.pop_armed, ARM_EN);
        hold('0, 4);
        check("arm_no_move", pulse_cnt - base, 0);
        hold(M_K5, 4);
        check("pop_count", pulse_cnt - base, 1);
        check("pop_button", last_btn, 4'd4);
        check("pop_flag", last_pop, ARM_EN);
        check("pop_armed_at_pulse", last_armed, 1'b0);
        hold('0, 4);
        hold(M_K5, 4);
        check("drop2_count", pulse_cnt - base, 2);
        check("drop2_button", last_btn, 4'd4);
        check("drop2_pop", last_pop, 1'b0);
        hold('0, 4);
        base = pulse_cnt;
        hold(M_KF, 4);
        check("rearm_set", kp_bus.pop_armed, ARM_EN);
        hold('0, 4);
        hold(M_K0, 4);
        check("key0_clear", kp_bus.pop_armed, 1'b0);
        hold('0, 4);
        check("f0_no_move", pulse_cnt - base, 0);

        // ---------------- bounce rejection (key 1) ----------------
        base = pulse_cnt;
        for (int i = 0; i < 5; i++) begin
            pressed = (i % 2 == 0) ? M_K1 : 16'h0000;
            wait_frames(1);
        end
        check("bounce_none", pulse_cnt - base, 0);
        wait_frames(4);
        check("bounce_count", pulse_cnt - base, 1);
        check("bounce_button", last_btn, 4'd0);
        hold('0, 4);

        // ---------------- multi-key ----------------
        base = pulse_cnt;
        hold(M_K2 | M_K4, 4);
        hold(M_K2, 4);
        check("multi_none", pulse_cnt - base, 0);
        hold('0, 4);
        hold(M_K2, 4);
        check("multi_after_count", pulse_cnt - base, 1);
        check("multi_after_button", last_btn, 4'd1);
        hold('0, 4);

        // ---------------- reset with key held ----------------
        base = pulse_cnt;
        pressed = M_K7;
        wait_frames(1);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_kp_col", kp_bus.kp_col, 4'b1110);
        reset = 1'b0;
        wait_frames(5);
        check("held_rst_none", pulse_cnt - base, 0);
        hold('0, 4);
        hold(M_K7, 4);
        check("key7_count", pulse_cnt - base, 1);
        check("key7_button", last_btn, 4'd6);
        hold('0, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
